// File: rtl/ahb_pkg.sv
// Shared AHB definitions: transfer-type encodings, default-slave FSM states,
// and the default two-region decode map.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  typedef logic [1:0] ds_state_t;
  localparam ds_state_t DS_IDLE = 2'd0;
  localparam ds_state_t DS_ERR1 = 2'd1;
  localparam ds_state_t DS_ERR2 = 2'd2;

  localparam int          DEF_NSLV   = 2;
  localparam logic [63:0] DEF_S_BASE = {32'h4000_0000, 32'h2000_0000};
  localparam logic [63:0] DEF_S_MASK = {32'hF000_0000, 32'hFF80_0000};

  // NONSEQ and SEQ carry a real transfer; IDLE and BUSY do not.
  function automatic logic htrans_active(input logic [1:0] t);
    logic act;
    case (t)
      HTRANS_NONSEQ, HTRANS_SEQ: act = 1'b1;
      HTRANS_IDLE, HTRANS_BUSY:  act = 1'b0;
      default:                   act = 1'b0;
    endcase
    return act;
  endfunction

endpackage

// File: rtl/ahb_default_slave.sv
// Default slave: answers unmapped transfers with a two-cycle ERROR response
// and keeps a saturating count of how many ERROR responses it started.
module ahb_default_slave
  import ahb_pkg::*;
#(
  parameter int ERRW = 8
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_hready,
  input  logic            i_req,
  output logic            o_hready,
  output logic            o_hresp,
  output logic [ERRW-1:0] o_err_cnt
);

  ds_state_t       r_state;
  ds_state_t       w_state_nxt;
  logic [ERRW-1:0] r_err_cnt;
  logic            w_err_entry;

  // Next state: new address phases are only taken on HREADY=1 edges
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      DS_IDLE: if (i_hready && i_req) w_state_nxt = DS_ERR1;
      DS_ERR1: w_state_nxt = DS_ERR2;
      DS_ERR2: w_state_nxt = (i_hready && i_req) ? DS_ERR1 : DS_IDLE;
      default: w_state_nxt = DS_IDLE;
    endcase
  end

  // ERR1 is never followed by ERR1, so a next state of ERR1 is always an entry
  assign w_err_entry = (w_state_nxt == DS_ERR1);

  // State register and saturating error counter
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= DS_IDLE;
      r_err_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_err_entry && (r_err_cnt != '1)) begin
        r_err_cnt <= r_err_cnt + ERRW'(1);
      end
    end
  end

  assign o_hready  = (r_state != DS_ERR1);
  assign o_hresp   = (r_state == DS_ERR1) || (r_state == DS_ERR2);
  assign o_err_cnt = r_err_cnt;

endmodule

// File: rtl/ahb_decoder_mux.sv
// AHB address decoder and slave-to-master response multiplexer with an
// internal default slave for unmapped addresses.
module ahb_decoder_mux
  import ahb_pkg::*;
#(
  parameter int                 NSLV   = DEF_NSLV,
  parameter logic [NSLV*32-1:0] S_BASE = DEF_S_BASE,
  parameter logic [NSLV*32-1:0] S_MASK = DEF_S_MASK,
  parameter int                 ERRW   = 8
) (
  input  logic                 HCLK,
  input  logic                 HRESET,
  input  logic                 EN,
  input  logic [31:0]          HADDR,
  input  logic [1:0]           HTRANS,
  output logic [NSLV-1:0]      HSEL,
  input  logic [NSLV*32-1:0]   HRDATA_S,
  input  logic [NSLV-1:0]      HREADYOUT_S,
  input  logic [NSLV-1:0]      HRESP_S,
  output logic [31:0]          HRDATA,
  output logic                 HREADY,
  output logic                 HRESP,
  output logic [ERRW-1:0]      ERR_CNT
);

  localparam int IDXW = (NSLV > 1) ? $clog2(NSLV) : 1;

  logic            w_hit;
  logic [IDXW-1:0] w_idx;
  logic            w_ds_req;
  logic            w_ds_hready;
  logic            w_ds_hresp;
  logic            r_sel_def;
  logic [IDXW-1:0] r_sel_idx;

  // Address decode: scan from the top down so the lowest matching index wins
  always_comb begin
    w_hit = 1'b0;
    w_idx = '0;
    for (int i = NSLV - 1; i >= 0; i--) begin
      if (EN && ((HADDR & S_MASK[32*i +: 32]) == S_BASE[32*i +: 32])) begin
        w_hit = 1'b1;
        w_idx = IDXW'(i);
      end
    end
  end

  // One-hot-or-zero slave select, purely from the address phase
  always_comb begin
    HSEL = '0;
    for (int i = 0; i < NSLV; i++) begin
      HSEL[i] = w_hit && (w_idx == IDXW'(i));
    end
  end

  assign w_ds_req = ~w_hit & htrans_active(HTRANS);

  // Data-phase selector: advances on HREADY=1, holds through wait states
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_sel_def <= 1'b1;
      r_sel_idx <= '0;
    end else if (HREADY) begin
      r_sel_def <= ~w_hit;
      r_sel_idx <= w_idx;
    end
  end

  // Response mux: selected slave, or the default slave when nothing matched
  always_comb begin
    HRDATA = '0;
    HREADY = w_ds_hready;
    HRESP  = w_ds_hresp;
    if (!r_sel_def) begin
      for (int i = 0; i < NSLV; i++) begin
        if (r_sel_idx == IDXW'(i)) begin
          HRDATA = HRDATA_S[32*i +: 32];
          HREADY = HREADYOUT_S[i];
          HRESP  = HRESP_S[i];
        end
      end
    end
  end

  ahb_default_slave #(
    .ERRW(ERRW)
  ) u_default_slave (
    .i_clk     (HCLK),
    .i_rst     (HRESET),
    .i_hready  (HREADY),
    .i_req     (w_ds_req),
    .o_hready  (w_ds_hready),
    .o_hresp   (w_ds_hresp),
    .o_err_cnt (ERR_CNT)
  );

endmodule

// File: tb/tb_ahb_decoder_mux.sv
// Directed bench for ahb_decoder_mux: three regions, 2-bit error counter,
// data-phase expectations queued at address phase and checked at completion.
module tb_ahb_decoder_mux;
  import ahb_pkg::*;

  localparam int          NSLV    = 3;
  localparam int          ERRW    = 2;
  localparam int          CNT_MAX = (1 << ERRW) - 1;
  localparam logic [95:0] BASE    = {32'h6000_0000, 32'h4000_0000, 32'h2000_0000};
  localparam logic [95:0] MASK    = {32'hE000_0000, 32'hF000_0000, 32'hFF80_0000};
  localparam logic [31:0] S0D     = 32'hA5A5_0000;
  localparam logic [31:0] S1D     = 32'h5A5A_1111;
  localparam logic [31:0] S2D     = 32'hC3C3_2222;

  logic                HCLK = 1'b0;
  logic                HRESET;
  logic                EN;
  logic [31:0]         HADDR;
  logic [1:0]          HTRANS;
  logic [NSLV-1:0]     HSEL;
  logic [NSLV*32-1:0]  HRDATA_S;
  logic [NSLV-1:0]     HREADYOUT_S;
  logic [NSLV-1:0]     HRESP_S;
  logic [31:0]         HRDATA;
  logic                HREADY;
  logic                HRESP;
  logic [ERRW-1:0]     ERR_CNT;

  ahb_decoder_mux #(
    .NSLV(NSLV), .S_BASE(BASE), .S_MASK(MASK), .ERRW(ERRW)
  ) dut (
    .HCLK(HCLK), .HRESET(HRESET), .EN(EN), .HADDR(HADDR), .HTRANS(HTRANS),
    .HSEL(HSEL), .HRDATA_S(HRDATA_S), .HREADYOUT_S(HREADYOUT_S), .HRESP_S(HRESP_S),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP), .ERR_CNT(ERR_CNT)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    string       tag;
    logic [31:0] rdata;
    logic        resp;
    int          waits;
    int          cnt;
  } exp_t;

  exp_t sb[$];
  int   n_cmp       = 0;
  int   n_err       = 0;
  int   model_cnt   = 0;
  int   slave_stall = 0;

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Complete the oldest queued data phase: count wait cycles, then compare
  task automatic dphase();
    exp_t e;
    int   nw;
    if (sb.size() == 0) return;
    e  = sb.pop_front();
    nw = 0;
    while ((HREADY !== 1'b1) && (nw < 8)) begin
      nw++;
      tick();
      if (slave_stall > 0) begin
        slave_stall--;
        if (slave_stall == 0) HREADYOUT_S = '1;
      end
      #3;
    end
    chk({e.tag, "_waits"}, nw, e.waits);
    chk({e.tag, "_hrdata"}, HRDATA, e.rdata);
    chk({e.tag, "_hresp"}, 32'(HRESP), 32'(e.resp));
    chk({e.tag, "_errcnt"}, 32'(ERR_CNT), e.cnt);
  endtask

  // Present one address phase, finish the previous data phase, queue this one
  task automatic step(input string tag, input logic [31:0] a, input logic [1:0] t,
                      input logic e, input logic [2:0] hs, input logic [31:0] rd,
                      input logic rsp, input int w, input bit is_err);
    exp_t x;
    HADDR  = a;
    HTRANS = t;
    EN     = e;
    #3;
    chk({tag, "_hsel"}, 32'(HSEL), 32'(hs));
    dphase();
    x.tag = tag;
    if (is_err) begin
      if (model_cnt < CNT_MAX) model_cnt++;
      x.rdata = '0;
      x.resp  = 1'b1;
      x.waits = 1;
    end else begin
      x.rdata = rd;
      x.resp  = rsp;
      x.waits = w;
    end
    x.cnt = model_cnt;
    sb.push_back(x);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    HRESET      = 1'b1;
    EN          = 1'b1;
    HADDR       = 32'h207F_FFFC;
    HTRANS      = HTRANS_IDLE;
    HRDATA_S    = {S2D, S1D, S0D};
    HREADYOUT_S = '1;
    HRESP_S     = '0;
    repeat (2) tick();
    HRESET = 1'b0;
    #3;
    chk("rst_hready", 32'(HREADY), 32'd1);
    chk("rst_hresp", 32'(HRESP), 32'd0);
    chk("rst_hrdata", HRDATA, 32'd0);
    chk("rst_errcnt", 32'(ERR_CNT), 32'd0);
    chk("rst_hsel", 32'(HSEL), 32'd1);
    tick();

    // Region 0 upper edge, then just past it, then region 2
    step("s1_slv0",   32'h207F_FFFC, HTRANS_NONSEQ, 1'b1, 3'b001, S0D, 1'b0, 0, 1'b0);
    step("s2_past0",  32'h2080_0000, HTRANS_IDLE,   1'b1, 3'b000, '0,  1'b0, 0, 1'b0);
    step("s3_slv2",   32'h7000_0000, HTRANS_NONSEQ, 1'b1, 3'b100, S2D, 1'b0, 0, 1'b0);
    // Unmapped NONSEQ -> ERROR, followed by an OKAY idle
    step("s4_unmap",  32'h0000_1000, HTRANS_NONSEQ, 1'b1, 3'b000, '0,  1'b0, 0, 1'b1);
    step("s5_idle",   32'h0000_1000, HTRANS_IDLE,   1'b1, 3'b000, '0,  1'b0, 0, 1'b0);
    // Decode disabled: SEQ gets ERROR, BUSY gets OKAY
    step("s6_en0seq", 32'h7000_0000, HTRANS_SEQ,    1'b0, 3'b000, '0,  1'b0, 0, 1'b1);
    step("s7_en0bsy", 32'h7000_0000, HTRANS_BUSY,   1'b0, 3'b000, '0,  1'b0, 0, 1'b0);
    // Slave 1 stalls three cycles while the next address targets slave 2
    HREADYOUT_S = 3'b101;
    slave_stall = 3;
    step("s8_slv1wt", 32'h4000_0010, HTRANS_NONSEQ, 1'b1, 3'b010, S1D, 1'b0, 3, 1'b0);
    step("s9_slv2",   32'h6000_0004, HTRANS_NONSEQ, 1'b1, 3'b100, S2D, 1'b0, 0, 1'b0);
    // Slave error response passes straight through
    HRESP_S = 3'b001;
    step("s10_slv0e", 32'h2000_0000, HTRANS_NONSEQ, 1'b1, 3'b001, S0D, 1'b1, 0, 1'b0);
    step("s11_idle",  32'h0000_1000, HTRANS_IDLE,   1'b1, 3'b000, '0,  1'b0, 0, 1'b0);
    HRESP_S = '0;

    // Reset while the default slave sits in ERR1
    HADDR  = 32'h0000_1000;
    HTRANS = HTRANS_NONSEQ;
    EN     = 1'b1;
    #3;
    chk("r44_hsel", 32'(HSEL), 32'd0);
    dphase();
    tick();
    if (model_cnt < CNT_MAX) model_cnt++;
    #3;
    chk("r44_err1_hready", 32'(HREADY), 32'd0);
    chk("r44_err1_hresp", 32'(HRESP), 32'd1);
    chk("r44_err1_cnt", 32'(ERR_CNT), model_cnt);
    HRESET = 1'b1;
    HTRANS = HTRANS_IDLE;
    tick();
    HRESET    = 1'b0;
    model_cnt = 0;
    #3;
    chk("r44_post_hready", 32'(HREADY), 32'd1);
    chk("r44_post_hresp", 32'(HRESP), 32'd0);
    chk("r44_post_hrdata", HRDATA, 32'd0);
    chk("r44_post_cnt", 32'(ERR_CNT), 32'd0);
    tick();
    #3;
    chk("r44_idle_hready", 32'(HREADY), 32'd1);
    chk("r44_idle_hresp", 32'(HRESP), 32'd0);
    tick();

    // Back-to-back unmapped transfers drive the 2-bit counter into saturation
    for (int k = 0; k < 5; k++) begin
      step($sformatf("r43_err%0d", k), 32'h0000_1000, HTRANS_NONSEQ, 1'b1, 3'b000,
           '0, 1'b0, 0, 1'b1);
    end
    step("r43_idle", 32'h0000_1000, HTRANS_IDLE, 1'b1, 3'b000, '0, 1'b0, 0, 1'b0);

    HTRANS = HTRANS_IDLE;
    #3;
    dphase();
    chk("sb_empty", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
